io_bank_fx: RTL and testbench

Responder side of the processor core's IO bus. Provides `NUIOIN` input ports, each with a valid/ready holding stage toward external producers, and `NUIOOU` registered output ports with one-cycle write strobes toward external consumers. Sits between the core (`req_in`/`addr_in`/`io_in`, `out_en`/`addr_out`/`data_out`) and the user peripherals at the top level.

---
 rtl/io_bank_fx_if.sv | 42 ++++
 rtl/io_bank_fx.sv | 205 ++++++++++++++++++++
 tb/tb_io_bank_fx.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_bank_fx_if.sv
// io_bank_fx_if: core-side IO bus between the processor core and io_bank_fx.
//
// Signals
//   req_in   : core read strobe, one cycle per read
//   addr_in  : read port select
//   io_in    : read data returned to the core (combinational in the bank)
//   out_en   : core write strobe
//   addr_out : write port select
//   data_out : write data from the core
//
// Handshake: a read completes in the cycle req_in is high (io_in is sampled
// by the core in that same cycle); a write completes at the edge where
// out_en is high. Neither side can stall the other on this bus.
//
// Modports
//   master : the core (drives strobes, addresses, write data)
//   slave  : the IO bank (drives read data)
interface io_bank_fx_if #(
  parameter int NUBITS = 32,
  parameter int NUIOIN = 8,
  parameter int NUIOOU = 8
);
  localparam int AIW = (NUIOIN > 1) ? $clog2(NUIOIN) : 1;
  localparam int AOW = (NUIOOU > 1) ? $clog2(NUIOOU) : 1;

  logic              req_in;
  logic [AIW-1:0]    addr_in;
  logic [NUBITS-1:0] io_in;
  logic              out_en;
  logic [AOW-1:0]    addr_out;
  logic [NUBITS-1:0] data_out;

  modport master (
    output req_in, addr_in, out_en, addr_out, data_out,
    input  io_in
  );

  modport slave (
    input  req_in, addr_in, out_en, addr_out, data_out,
    output io_in
  );
endinterface

// File: rtl/io_bank_fx.sv
// io_bank_fx: responder side of the core IO bus.
//
// NUIOIN input ports, each a one-entry holding stage with a valid/ready
// handshake toward an external producer, and NUIOOU registered output ports
// with a one-cycle write strobe toward external consumers.
//
// Optional feature macro: IO_FIFO_EN
//   defined   : input port 0 is an FDEPTH-entry FIFO instead of a holding
//               register.
//   undefined : port 0 is a plain holding register like every other port.
//
// Ports
//   clk         : clock, rising edge
//   rst         : asynchronous active-low reset
//   bus         : core bus (io_bank_fx_if.slave)
//   in_data     : producer data, port i at [i*NUBITS +: NUBITS]
//   in_valid    : producer valid, one bit per port
//   in_ready    : port can accept; transfer when valid & ready at an edge
//   out_data    : registered output values, same packing as in_data
//   out_stb     : one-cycle pulse per written output port
//   in_underrun : sticky, port was read while empty
//
// Producer handshake: a word moves when in_valid[i] & in_ready[i] are both
// high at a rising edge. in_ready comes straight from a flop, so it never
// depends combinationally on the core's read strobe.
module io_bank_fx #(
  parameter int NUBITS = 32,
  parameter int NUIOIN = 8,
  parameter int NUIOOU = 8,
  parameter int FDEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  io_bank_fx_if.slave              bus,
  input  logic [NUIOIN*NUBITS-1:0] in_data,
  input  logic [NUIOIN-1:0]        in_valid,
  output logic [NUIOIN-1:0]        in_ready,
  output logic [NUIOOU*NUBITS-1:0] out_data,
  output logic [NUIOOU-1:0]        out_stb,
  output logic [NUIOIN-1:0]        in_underrun
);
  localparam int AIW = (NUIOIN > 1) ? $clog2(NUIOIN) : 1;
  localparam int AOW = (NUIOOU > 1) ? $clog2(NUIOOU) : 1;

`ifdef IO_FIFO_EN
  localparam int PW        = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
  // Port 0 is served by the FIFO; the register loop starts at port 1.
  localparam int FIRST_REG = 1;
`else
  localparam int FIRST_REG = 0;
`endif

  // Holding stages. With the FIFO, hold_q[0] keeps the last popped value
  // and full_q[0] mirrors "FIFO full" so in_ready stays a plain ~full_q.
  logic [NUBITS-1:0]        hold_q [NUIOIN];
  logic [NUBITS-1:0]        hold_d [NUIOIN];
  logic [NUIOIN-1:0]        full_q, full_d;
  logic [NUIOIN-1:0]        underrun_q, underrun_d;
  logic [NUIOOU*NUBITS-1:0] out_data_q, out_data_d;
  logic [NUIOOU-1:0]        out_stb_q, out_stb_d;

  logic [AIW-1:0]    rd_idx;
  logic [AOW-1:0]    wr_idx;
  logic              rd_in_range, wr_in_range;
  logic              rd_hit;
  logic [NUIOIN-1:0] port_avail;  // port holds unread data
  logic [NUBITS-1:0] io_in_w;

  assign rd_idx = bus.addr_in;
  assign wr_idx = bus.addr_out;

  // Address range checks only exist for non-power-of-two port counts.
  if (NUIOIN == (1 << AIW)) begin : g_rd_all
    assign rd_in_range = 1'b1;
  end else begin : g_rd_part
    assign rd_in_range = ({1'b0, rd_idx} < (AIW+1)'(NUIOIN));
  end

  if (NUIOOU == (1 << AOW)) begin : g_wr_all
    assign wr_in_range = 1'b1;
  end else begin : g_wr_part
    assign wr_in_range = ({1'b0, wr_idx} < (AOW+1)'(NUIOOU));
  end

  assign rd_hit = bus.req_in & rd_in_range;

`ifdef IO_FIFO_EN
  logic [NUBITS-1:0] fifo_mem_q [FDEPTH];
  logic [NUBITS-1:0] fifo_mem_d [FDEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]       count_q, count_d;
  logic              fifo_empty, fifo_full, push, pop;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (PW+1)'(FDEPTH));
  assign push       = in_valid[0] & ~fifo_full;
  assign pop        = rd_hit & (rd_idx == '0) & ~fifo_empty;
`endif

  always_comb begin
    port_avail = full_q;
`ifdef IO_FIFO_EN
    port_avail[0] = ~fifo_empty;
`endif
  end

  // Next-state for input ports.
  always_comb begin
    hold_d     = hold_q;
    full_d     = full_q;
    underrun_d = underrun_q;

    // A full port has in_ready low, so a producer write and a read of the
    // same full port can never collide: the read always gets the old word.
    for (int i = FIRST_REG; i < NUIOIN; i++) begin
      if (in_valid[i] && !full_q[i]) begin
        hold_d[i] = in_data[i*NUBITS +: NUBITS];
        full_d[i] = 1'b1;
      end
    end

    if (rd_hit) begin
      if (port_avail[rd_idx]) full_d[rd_idx]     = 1'b0;
      else                    underrun_d[rd_idx] = 1'b1;
    end

`ifdef IO_FIFO_EN
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push) begin
      fifo_mem_d[wr_ptr_q] = in_data[NUBITS-1:0];
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      hold_d[0] = fifo_mem_q[rd_ptr_q];
      rd_ptr_d  = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d[0] = (count_d == (PW+1)'(FDEPTH));
`endif
  end

  // Output slots: strobes are single-cycle, data persists.
  always_comb begin
    out_data_d = out_data_q;
    out_stb_d  = '0;
    if (bus.out_en && wr_in_range) begin
      out_data_d[int'(wr_idx)*NUBITS +: NUBITS] = bus.data_out;
      out_stb_d[wr_idx]                          = 1'b1;
    end
  end

  // Read data is combinational from addr_in regardless of req_in.
  always_comb begin
    io_in_w = '0;
    if (rd_in_range) io_in_w = hold_q[rd_idx];
`ifdef IO_FIFO_EN
    if (rd_in_range && (rd_idx == '0) && !fifo_empty) io_in_w = fifo_mem_q[rd_ptr_q];
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUIOIN; i++) hold_q[i] <= '0;
      full_q     <= '0;
      underrun_q <= '0;
      out_data_q <= '0;
      out_stb_q  <= '0;
    end else begin
      for (int i = 0; i < NUIOIN; i++) hold_q[i] <= hold_d[i];
      full_q     <= full_d;
      underrun_q <= underrun_d;
      out_data_q <= out_data_d;
      out_stb_q  <= out_stb_d;
    end
  end

`ifdef IO_FIFO_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FDEPTH; i++) fifo_mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < FDEPTH; i++) fifo_mem_q[i] <= fifo_mem_d[i];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
`endif

  assign bus.io_in   = io_in_w;
  assign in_ready    = ~full_q;
  assign out_data    = out_data_q;
  assign out_stb     = out_stb_q;
  assign in_underrun = underrun_q;

endmodule

// File: tb/tb_io_bank_fx.sv
// tb_io_bank_fx: directed bench for io_bank_fx. Read and write responses go
// through expected queues checked by a negedge monitor; handshake, flag and
// reset values are checked directly. A second instance with six input ports
// covers out-of-range read addresses.
module tb_io_bank_fx;
  localparam int NUBITS = 32;
  localparam int NUIOIN = 8;
  localparam int NUIOOU = 8;
  localparam int NI6    = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT (8 in / 8 out) ----------------
  io_bank_fx_if #(.NUBITS(NUBITS), .NUIOIN(NUIOIN), .NUIOOU(NUIOOU)) bus ();
  logic [NUIOIN*NUBITS-1:0] in_data;
  logic [NUIOIN-1:0]        in_valid, in_ready, in_underrun;
  logic [NUIOOU*NUBITS-1:0] out_data;
  logic [NUIOOU-1:0]        out_stb;

  io_bank_fx #(.NUBITS(NUBITS), .NUIOIN(NUIOIN), .NUIOOU(NUIOOU), .FDEPTH(4)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_stb(out_stb), .in_underrun(in_underrun)
  );

  // ---------------- DUT (6 in / 8 out) ----------------
  io_bank_fx_if #(.NUBITS(NUBITS), .NUIOIN(NI6), .NUIOOU(NUIOOU)) bus6 ();
  logic [NI6*NUBITS-1:0]    in_data6;
  logic [NI6-1:0]           in_valid6, in_ready6, in_underrun6;
  logic [NUIOOU*NUBITS-1:0] out_data6;
  logic [NUIOOU-1:0]        out_stb6;

  io_bank_fx #(.NUBITS(NUBITS), .NUIOIN(NI6), .NUIOOU(NUIOOU), .FDEPTH(4)) dut6 (
    .clk(clk), .rst(rst), .bus(bus6),
    .in_data(in_data6), .in_valid(in_valid6), .in_ready(in_ready6),
    .out_data(out_data6), .out_stb(out_stb6), .in_underrun(in_underrun6)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [NUBITS-1:0]               exp_q[$];
  logic [NUIOOU+NUIOOU*NUBITS-1:0] exp_wr_q[$];
  logic [NUIOOU*NUBITS-1:0]        out_model;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: reads are observed in the req_in cycle, writes when a strobe shows.
  always @(negedge clk) begin
    if (rst && bus.req_in) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL rd_unexpected: got read of port %0d with no expected entry", bus.addr_in);
      end else begin
        chk("rd_data", 256'(bus.io_in), 256'(exp_q.pop_front()));
      end
    end
    if (out_stb != '0) begin
      if (exp_wr_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL wr_unexpected: got strobe %0h expected none", out_stb);
      end else begin
        logic [NUIOOU+NUIOOU*NUBITS-1:0] e;
        e = exp_wr_q.pop_front();
        chk("wr_stb", 256'(out_stb), 256'(e[NUIOOU*NUBITS +: NUIOOU]));
        chk("wr_data", out_data, e[NUIOOU*NUBITS-1:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic produce(input int port, input logic [NUBITS-1:0] d);
    in_data[port*NUBITS +: NUBITS] = d;
    in_valid[port] = 1'b1;
    tick();
    in_valid[port] = 1'b0;
  endtask

  task automatic rd(input int port, input logic [NUBITS-1:0] exp);
    bus.req_in  = 1'b1;
    bus.addr_in = 3'(port);
    exp_q.push_back(exp);
    tick();
    bus.req_in = 1'b0;
  endtask

  task automatic wr(input int port, input logic [NUBITS-1:0] d);
    logic [NUIOOU-1:0] stb;
    stb = '0;
    stb[port] = 1'b1;
    bus.out_en   = 1'b1;
    bus.addr_out = 3'(port);
    bus.data_out = d;
    out_model[port*NUBITS +: NUBITS] = d;
    exp_wr_q.push_back({stb, out_model});
    tick();
    bus.out_en = 1'b0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    in_data = '0; in_valid = '0;
    in_data6 = '0; in_valid6 = '0;
    bus.req_in = 1'b0; bus.addr_in = '0; bus.out_en = 1'b0; bus.addr_out = '0; bus.data_out = '0;
    bus6.req_in = 1'b0; bus6.addr_in = '0; bus6.out_en = 1'b0; bus6.addr_out = '0; bus6.data_out = '0;
    out_model = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    tick();

    // Reset state
    chk("rst_in_ready", 256'(in_ready), 256'(8'hFF));
    chk("rst_underrun", 256'(in_underrun), 256'(0));
    chk("rst_out_stb", 256'(out_stb), 256'(0));
    chk("rst_out_data", out_data, 256'(0));
    chk("rst_io_in", 256'(bus.io_in), 256'(0));

    // Input handshake on port 3
    produce(3, 32'h0000_1234);
    chk("hs_ready_low", 256'(in_ready), 256'(8'hF7));
    rd(3, 32'h0000_1234);
    chk("hs_ready_back", 256'(in_ready), 256'(8'hFF));

    // Underrun on empty port 5, flag stays after a good read
    rd(5, 32'h0);
    chk("underrun_set", 256'(in_underrun), 256'(8'h20));
    produce(5, 32'h0000_ABCD);
    rd(5, 32'h0000_ABCD);
    chk("underrun_sticky", 256'(in_underrun), 256'(8'h20));
    rd(5, 32'h0000_ABCD);  // empty again: last held value
    chk("underrun_again", 256'(in_underrun), 256'(8'h20));

    // Two ports loaded in one cycle
    in_data[1*NUBITS +: NUBITS] = 32'hCAFE_0001;
    in_data[6*NUBITS +: NUBITS] = 32'hBEEF_0006;
    in_valid = 8'h42;
    tick();
    in_valid = '0;
    chk("two_ready", 256'(in_ready), 256'(8'hBD));
    rd(6, 32'hBEEF_0006);
    rd(1, 32'hCAFE_0001);
    chk("two_ready_back", 256'(in_ready), 256'(8'hFF));

    // Producer holds valid while the port is full; read takes the old word
    in_data[4*NUBITS +: NUBITS] = 32'h11;
    in_valid[4] = 1'b1;
    tick();
    in_data[4*NUBITS +: NUBITS] = 32'h22;
    rd(4, 32'h11);
    tick();  // 0x22 accepted now that ready is back
    in_valid[4] = 1'b0;
    chk("hold_ready", 256'(in_ready), 256'(8'hEF));
    rd(4, 32'h22);

    // Output writes
    wr(2, 32'hFFFF_FFC0);
    tick();
    wr(2, 32'h1111_2222);
    wr(2, 32'h3333_4444);
    wr(7, 32'h7777_0007);
    tick(); tick();
    chk("out_idle", 256'(out_stb), 256'(0));

    // Out-of-range read on the six-port instance
    in_data6[5*NUBITS +: NUBITS] = 32'h66;
    in_valid6[5] = 1'b1;
    tick();
    in_valid6[5] = 1'b0;
    bus6.req_in = 1'b1;
    bus6.addr_in = 3'd7;
    #1;
    chk("oor_io_in", 256'(bus6.io_in), 256'(0));
    tick();
    bus6.req_in = 1'b0;
    chk("oor_underrun", 256'(in_underrun6), 256'(0));
    chk("oor_ready", 256'(in_ready6), 256'(6'h1F));
    bus6.addr_in = 3'd5;
    #1;
    chk("oor_inrange", 256'(bus6.io_in), 256'(32'h66));

`ifdef IO_FIFO_EN
    // FIFO on port 0
    in_valid[0] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      in_data[NUBITS-1:0] = 32'(k);
      tick();
    end
    in_valid[0] = 1'b0;
    chk("fifo_full", 256'(in_ready[0]), 256'(0));
    rd(0, 32'd1);
    rd(0, 32'd2);
    rd(0, 32'd3);
    rd(0, 32'd4);
    chk("fifo_no_underrun", 256'(in_underrun[0]), 256'(0));
    rd(0, 32'd4);
    chk("fifo_underrun", 256'(in_underrun[0]), 256'(1));
    produce(0, 32'd7);
    rd(0, 32'd7);
    rd(0, 32'd7);
    for (int k = 0; k < 6; k++) begin
      produce(0, 32'h70 + 32'(k));
      rd(0, 32'h70 + 32'(k));
    end
    produce(0, 32'd8);
    in_data[NUBITS-1:0] = 32'd9;
    in_valid[0] = 1'b1;
    rd(0, 32'd8);  // push 9 and pop 8 together
    in_valid[0] = 1'b0;
    rd(0, 32'd9);
    chk("fifo_ready_end", 256'(in_ready[0]), 256'(1));
`endif

    // Mid-cycle asynchronous reset with state held
    produce(3, 32'h55);
    bus.addr_in = 3'd3;
    #1;
    chk("io_in_no_req", 256'(bus.io_in), 256'(32'h55));
    @(posedge clk);
    #3;
    rst = 1'b0;
    bus.out_en = 1'b1; bus.addr_out = 3'd1; bus.data_out = 32'hDEAD;
    #1;
    chk("arst_in_ready", 256'(in_ready), 256'(8'hFF));
    chk("arst_underrun", 256'(in_underrun), 256'(0));
    chk("arst_out_stb", 256'(out_stb), 256'(0));
    chk("arst_out_data", out_data, 256'(0));
    chk("arst_io_in", 256'(bus.io_in), 256'(0));
    tick();
    bus.out_en = 1'b0;
    rst = 1'b1;
    out_model = '0;
    tick(); tick();
    chk("post_rst_out_data", out_data, 256'(0));

    tick(); tick();
    chk("rd_queue_empty", 256'(exp_q.size()), 256'(0));
    chk("wr_queue_empty", 256'(exp_wr_q.size()), 256'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
